// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter onto one slave bus with a per-access ready watchdog
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   m0_* (ibus), m1_* (dbus)        req/as/rw/addr/wr_data in; get/ready/rd_data out
//   s_as/s_rw/s_addr/s_wr_data      forwarded request of the current owner (0 when idle)
//   s_rd_data/s_ready               slave response, routed back to the owner only
//   bus_err                         one-cycle pulse when the slave fails to answer in time
module bus_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_as,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_get,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_as,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_get,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              s_as,
  output logic              s_rw,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wr_data,
  input  logic [DATA_W-1:0] s_rd_data,
  input  logic              s_ready,
  output logic              bus_err
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t            state, state_n;
  logic              last, last_n;
  logic              busy;
  logic              to_pulse;
  logic [TO_W-1:0]   to_cnt;
  logic              own, sel1, hit, done, rel0, rel1;
  assign own  = state != IDLE;
  assign sel1 = state == OWN1;
  // an owner may only let go once its outstanding access has finished
  assign rel0 = state == OWN0 && !busy && !m0_req;
  assign rel1 = state == OWN1 && !busy && !m1_req;
  always_comb begin
    state_n = state;
    last_n  = last;
    if (state == IDLE)
      state_n = (m0_req && m1_req) ? (last ? OWN0 : OWN1) :
                m1_req ? OWN1 : m0_req ? OWN0 : IDLE;
    else if (rel0) begin
      state_n = m1_req ? OWN1 : IDLE;
      last_n  = 1'b0;
    end else if (rel1) begin
      state_n = m0_req ? OWN0 : IDLE;
      last_n  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b0;
      busy     <= 1'b0;
      to_cnt   <= '0;
      to_pulse <= 1'b0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      to_pulse <= 1'b0;
      if (s_as) begin
        busy   <= 1'b1;
        to_cnt <= '0;
      end else if (busy) begin
        if (s_ready)
          busy <= 1'b0;
        else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          busy     <= 1'b0;
          to_pulse <= 1'b1;
        end else
          to_cnt <= to_cnt + 1'b1;
      end
    end
  end
  // strobes arriving while an access is outstanding are dropped
  assign s_as      = own && !busy && (sel1 ? m1_as : m0_as);
  assign s_rw      = own && (sel1 ? m1_rw : m0_rw);
  assign s_addr    = own ? (sel1 ? m1_addr : m0_addr) : '0;
  assign s_wr_data = own ? (sel1 ? m1_wr_data : m0_wr_data) : '0;
  assign hit       = busy && s_ready;
  assign done      = hit || to_pulse;
  assign m0_get    = state == OWN0;
  assign m1_get    = state == OWN1;
  assign m0_ready  = m0_get && done;
  assign m1_ready  = m1_get && done;
  assign m0_rd_data = (m0_get && hit) ? s_rd_data : '0;
  assign m1_rd_data = (m1_get && hit) ? s_rd_data : '0;
  assign bus_err   = to_pulse;
endmodule
